// File: rtl/titan_csr_unit.sv
// Machine-mode CSR file for the Titan core: counters, trap state, interrupt
// sampling and illegal-access detection. Reads are combinational; updates commit on clk_i.
module titan_csr_unit #(
  parameter int          NUM_HPM         = 4,
  parameter int          NUM_EVENTS      = 8,
  parameter int          COUNTER_WIDTH   = 64,
  parameter bit          ENABLE_VECTORED = 1'b1,
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter logic [31:0] HART_ID         = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  csr_valid_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [1:0]            csr_op_i,
  input  logic                  csr_we_i,
  input  logic [31:0]           csr_wdat_i,
  output logic [31:0]           csr_rdat_o,
  output logic                  csr_illegal_o,
  input  logic                  xint_meip_i,
  input  logic                  xint_mtip_i,
  input  logic                  xint_msip_i,
  input  logic [NUM_EVENTS-1:0] hpm_event_i,
  input  logic                  instret_i,
  input  logic                  trap_valid_i,
  input  logic [4:0]            trap_cause_i,
  input  logic [31:0]           trap_pc_i,
  input  logic [31:0]           trap_tval_i,
  input  logic                  mret_i,
  output logic [31:0]           trap_vector_o,
  output logic [31:0]           mepc_o,
  output logic                  irq_pending_o,
  output logic [3:0]            irq_cause_o
);
  localparam int CW = COUNTER_WIDTH;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic          mie_bit, mpie_bit;
  logic [2:0]    mie_reg;   // {MEIE, MTIE, MSIE}
  logic [2:0]    mip_reg;   // {MEIP, MTIP, MSIP}
  logic [29:0]   mtvec_base;
  logic          mtvec_mode;
  logic [31:0]   inhibit, mscratch, mepc, mcause, mtval;
  logic [4:0]    hpm_event_sel [NUM_HPM];
  logic [CW-1:0] mcycle, minstret;
  logic [CW-1:0] hpm_cnt [NUM_HPM];

  logic [4:0]         idx;
  logic               is_hpmevent, is_cnt_m, is_cnt_u, mapped, wr;
  logic               wr_lo, wr_hi;
  logic [31:0]        rdat, wv, ev_ext, ev_sel_rd;
  logic [63:0]        cnt_sel;
  logic [NUM_HPM-1:0] hpm_inc;
  logic [2:0]         pending;

  assign idx         = csr_addr_i[4:0];
  assign is_hpmevent = (csr_addr_i[11:5] == 7'b0011_001) && (idx >= 5'd3);
  assign is_cnt_m    = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[6:5] == 2'b00) && (idx != 5'd1);
  assign is_cnt_u    = (csr_addr_i[11:8] == 4'hC) && (csr_addr_i[6:5] == 2'b00) &&
                       ((idx == 5'd0) || (idx == 5'd2));

  // Selected counter and event selector, zero-extended so unimplemented slots read 0.
  always_comb begin
    cnt_sel   = '0;
    ev_sel_rd = '0;
    if (idx == 5'd0)      cnt_sel[CW-1:0] = mcycle;
    else if (idx == 5'd2) cnt_sel[CW-1:0] = minstret;
    for (int i = 0; i < NUM_HPM; i++) begin
      if (idx == 5'(i + 3)) begin
        cnt_sel[CW-1:0] = hpm_cnt[i];
        ev_sel_rd[4:0]  = hpm_event_sel[i];
      end
    end
  end

  always_comb begin
    rdat   = '0;
    mapped = 1'b1;
    if (is_cnt_m || is_cnt_u) begin
      rdat = csr_addr_i[7] ? cnt_sel[63:32] : cnt_sel[31:0];
    end else if (is_hpmevent) begin
      rdat = ev_sel_rd;
    end else begin
      case (csr_addr_i)
        12'h300: rdat = {19'b0, 2'b11, 3'b0, mpie_bit, 3'b0, mie_bit, 3'b0};
        12'h301: rdat = 32'h4000_0100;
        12'h304: rdat = {20'b0, mie_reg[2], 3'b0, mie_reg[1], 3'b0, mie_reg[0], 3'b0};
        12'h305: rdat = {mtvec_base, 1'b0, mtvec_mode};
        12'h320: rdat = inhibit;
        12'h340: rdat = mscratch;
        12'h341: rdat = mepc;
        12'h342: rdat = mcause;
        12'h343: rdat = mtval;
        12'h344: rdat = {20'b0, mip_reg[2], 3'b0, mip_reg[1], 3'b0, mip_reg[0], 3'b0};
        12'hF11, 12'hF12, 12'hF13: rdat = '0;
        12'hF14: rdat = HART_ID;
        default: mapped = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (csr_op_i)
      2'b01:   wv = csr_wdat_i;
      2'b10:   wv = rdat | csr_wdat_i;
      2'b11:   wv = rdat & ~csr_wdat_i;
      default: wv = rdat;
    endcase
  end

  assign csr_rdat_o    = rdat;
  assign csr_illegal_o = csr_valid_i && (!mapped || (csr_we_i && (csr_addr_i[11:10] == 2'b11)));
  assign wr            = csr_valid_i && csr_we_i && !csr_illegal_o && !trap_valid_i;
  assign wr_lo         = wr && is_cnt_m && !csr_addr_i[7];
  assign wr_hi         = wr && is_cnt_m && csr_addr_i[7];

  // Event index 0 means "none", so bit 0 of the extended vector is tied low.
  assign ev_ext = 32'({hpm_event_i, 1'b0});

  for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm_inc
    assign hpm_inc[gi] = ev_ext[hpm_event_sel[gi]] && !inhibit[3+gi];
  end

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur, input logic lo,
                                             input logic hi, input logic inc,
                                             input logic [31:0] val);
    cnt_next = cur;
    if (lo)       cnt_next[31:0]    = val;
    else if (hi)  cnt_next[CW-1:32] = val[CW-33:0];
    else if (inc) cnt_next          = cur + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle   <= '0;
      minstret <= '0;
      for (int i = 0; i < NUM_HPM; i++) begin
        hpm_cnt[i]       <= '0;
        hpm_event_sel[i] <= '0;
      end
    end else begin
      mcycle   <= cnt_next(mcycle, wr_lo && idx == 5'd0, wr_hi && idx == 5'd0, !inhibit[0], wv);
      minstret <= cnt_next(minstret, wr_lo && idx == 5'd2, wr_hi && idx == 5'd2,
                           instret_i && !inhibit[2], wv);
      for (int i = 0; i < NUM_HPM; i++) begin
        hpm_cnt[i] <= cnt_next(hpm_cnt[i], wr_lo && idx == 5'(i + 3), wr_hi && idx == 5'(i + 3),
                               hpm_inc[i], wv);
        if (wr && is_hpmevent && idx == 5'(i + 3)) hpm_event_sel[i] <= wv[4:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_bit    <= 1'b0;
      mpie_bit   <= 1'b0;
      mie_reg    <= '0;
      mip_reg    <= '0;
      mtvec_base <= RESET_ADDR[31:2];
      mtvec_mode <= 1'b0;
      inhibit    <= '0;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else begin
      mip_reg <= {xint_meip_i, xint_mtip_i, xint_msip_i};
      if (trap_valid_i) begin
        mepc     <= {trap_pc_i[31:2], 2'b00};
        mcause   <= {trap_cause_i[4], 27'b0, trap_cause_i[3:0]};
        mtval    <= trap_tval_i;
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
      end else if (mret_i) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end else if (wr && csr_addr_i == 12'h300) begin
        mie_bit  <= wv[3];
        mpie_bit <= wv[7];
      end
      if (wr) begin
        case (csr_addr_i)
          12'h304: mie_reg <= {wv[11], wv[7], wv[3]};
          12'h305: begin
            mtvec_base <= wv[31:2];
            mtvec_mode <= ENABLE_VECTORED && (wv[1:0] == 2'b01);
          end
          12'h320: inhibit  <= wv & INH_MASK;
          12'h340: mscratch <= wv;
          12'h341: mepc     <= {wv[31:2], 2'b00};
          12'h342: mcause   <= wv;
          12'h343: mtval    <= wv;
          default: ;
        endcase
      end
    end
  end

  // Priority among enabled pending lines: external, then software, then timer.
  assign pending       = mip_reg & mie_reg;
  assign irq_pending_o = mie_bit && (|pending);
  always_comb begin
    irq_cause_o = 4'd0;
    if (irq_pending_o) begin
      if (pending[2])      irq_cause_o = 4'd11;
      else if (pending[0]) irq_cause_o = 4'd3;
      else                 irq_cause_o = 4'd7;
    end
  end

  assign trap_vector_o = (mtvec_mode && trap_cause_i[4]) ?
                         {mtvec_base, 2'b00} + {26'b0, trap_cause_i[3:0], 2'b00} :
                         {mtvec_base, 2'b00};
  assign mepc_o = mepc;
endmodule
